// File: rtl/vga_timing.sv
// Raster timing generator: registered hsync/vsync/de, pixel coordinates and line/frame strobes.
// Optional colour-bar pattern on rgb when VGA_TEST_PATTERN_EN is defined; otherwise rgb is tied to 0.
module vga_timing #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [11:0] pix_x,
  output logic [11:0] pix_y,
  output logic        line_start,
  output logic        frame_start,
  output logic [11:0] rgb
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_ACT  = 12'(H_ACTIVE);
  localparam logic [11:0] V_ACT  = 12'(V_ACTIVE);
  localparam logic [11:0] HS_BEG = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] VS_BEG = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END = 12'(V_ACTIVE + V_FP + V_SYNC);

  if (H_TOTAL > 4096 || V_TOTAL > 4096) begin : g_bad_total
    $error("vga_timing: H_TOTAL/V_TOTAL exceed 4096");
  end
  if (H_ACTIVE % 8 != 0) begin : g_bad_hact
    $error("vga_timing: H_ACTIVE must be a multiple of 8");
  end

  // run is clear after reset so the first enabled edge presents (0,0) instead of advancing past it
  logic        run;
  logic [11:0] nx, ny;
  logic        de_n, hs_n, vs_n;

  always_comb begin
    nx = pix_x;
    ny = pix_y;
    if (run) begin
      if (pix_x == H_LAST) begin
        nx = 12'd0;
        ny = (pix_y == V_LAST) ? 12'd0 : pix_y + 12'd1;
      end else begin
        nx = pix_x + 12'd1;
      end
    end
    de_n = (nx < H_ACT) && (ny < V_ACT);
    hs_n = (nx >= HS_BEG && nx < HS_END) ? HS_POL : ~HS_POL;
    vs_n = (ny >= VS_BEG && ny < VS_END) ? VS_POL : ~VS_POL;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run         <= 1'b0;
      pix_x       <= 12'd0;
      pix_y       <= 12'd0;
      de          <= 1'b0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (en) begin
      run         <= 1'b1;
      pix_x       <= nx;
      pix_y       <= ny;
      de          <= de_n;
      hsync       <= hs_n;
      vsync       <= vs_n;
      line_start  <= (nx == 12'd0);
      frame_start <= (nx == 12'd0) && (ny == 12'd0);
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  localparam logic [11:0] BAR_LAST = 12'(H_ACTIVE / 8 - 1);

  // bar_cnt/bar_idx track the presented pixel; a width counter replaces a divide by BAR_W
  logic [11:0] bar_cnt, bar_cnt_n;
  logic [2:0]  bar_idx, bar_idx_n;
  logic [11:0] rgb_n;

  always_comb begin
    bar_cnt_n = bar_cnt;
    bar_idx_n = bar_idx;
    if (nx == 12'd0) begin
      bar_cnt_n = 12'd0;
      bar_idx_n = 3'd0;
    end else if (bar_cnt == BAR_LAST) begin
      bar_cnt_n = 12'd0;
      bar_idx_n = bar_idx + 3'd1;
    end else begin
      bar_cnt_n = bar_cnt + 12'd1;
    end
    case (bar_idx_n)
      3'd0:    rgb_n = 12'hFFF;
      3'd1:    rgb_n = 12'hFF0;
      3'd2:    rgb_n = 12'h0FF;
      3'd3:    rgb_n = 12'h0F0;
      3'd4:    rgb_n = 12'hF0F;
      3'd5:    rgb_n = 12'hF00;
      3'd6:    rgb_n = 12'h00F;
      default: rgb_n = 12'h000;
    endcase
    if (!de_n) rgb_n = 12'h000;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bar_cnt <= 12'd0;
      bar_idx <= 3'd0;
      rgb     <= 12'h000;
    end else if (en) begin
      bar_cnt <= bar_cnt_n;
      bar_idx <= bar_idx_n;
      rgb     <= rgb_n;
    end
  end
`else
  assign rgb = 12'h000;
`endif

endmodule

// File: tb/tb_vga_timing.sv
// Scoreboard bench for vga_timing on a reduced raster (24x10) so full frames stay short.
module tb_vga_timing;
  localparam int HA = 16, HF = 2, HS = 3, HB = 3;
  localparam int VA = 6,  VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;  // 24
  localparam int VT = VA + VF + VS + VB;  // 10

  logic        clk = 1'b0, rst = 1'b1, en = 1'b0;
  logic        hsync, vsync, de, line_start, frame_start;
  logic [11:0] pix_x, pix_y, rgb;

  vga_timing #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .en(en),
    .hsync(hsync), .vsync(vsync), .de(de),
    .pix_x(pix_x), .pix_y(pix_y),
    .line_start(line_start), .frame_start(frame_start),
    .rgb(rgb)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        hs, vs, de, ls, fs, cnt;
    logic [11:0] x, y, rgb;
  } exp_t;

  exp_t q[$];
  int   total = 0, bad = 0;
  int   n_fs = 0, n_ls = 0, n_de = 0, n_hs = 0, n_vs = 0, n_rgb = 0;

  bit   run = 1'b0, cnt_on = 1'b0;
  int   mx = 0, my = 0;
  exp_t last = '0;

  function automatic logic [11:0] bar_colour(input int x);
    logic [11:0] c;
    case (x / (HA / 8))
      0: c = 12'hFFF; 1: c = 12'hFF0; 2: c = 12'h0FF; 3: c = 12'h0F0;
      4: c = 12'hF0F; 5: c = 12'hF00; 6: c = 12'h00F; default: c = 12'h000;
    endcase
    return c;
  endfunction

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s t=%0t: got %0h expected %0h", nm, $time, act, req);
    end
  endtask

  // drive one cycle of inputs and queue what the outputs must show after the next edge
  task automatic step(input logic r, input logic e);
    @(negedge clk);
    rst = r;
    en  = e;
    if (r) begin
      run = 1'b0; mx = 0; my = 0;
      last = '0;
      last.hs = 1'b1;
      last.vs = 1'b1;
    end else if (e) begin
      if (run) begin
        if (mx == HT - 1) begin
          mx = 0;
          my = (my == VT - 1) ? 0 : my + 1;
        end else mx++;
      end
      run     = 1'b1;
      last.x  = 12'(mx);
      last.y  = 12'(my);
      last.de = (mx < HA) && (my < VA);
      last.hs = !(mx >= HA + HF && mx < HA + HF + HS);
      last.vs = !(my >= VA + VF && my < VA + VF + VS);
      last.ls = (mx == 0);
      last.fs = (mx == 0) && (my == 0);
`ifdef VGA_TEST_PATTERN_EN
      last.rgb = last.de ? bar_colour(mx) : 12'h000;
`else
      last.rgb = 12'h000;
`endif
    end
    last.cnt = cnt_on;
    q.push_back(last);
  endtask

  always @(posedge clk) begin : mon
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("pix_x", int'(pix_x), int'(e.x));
      chk("pix_y", int'(pix_y), int'(e.y));
      chk("de", int'(de), int'(e.de));
      chk("hsync", int'(hsync), int'(e.hs));
      chk("vsync", int'(vsync), int'(e.vs));
      chk("line_start", int'(line_start), int'(e.ls));
      chk("frame_start", int'(frame_start), int'(e.fs));
      chk("rgb", int'(rgb), int'(e.rgb));
      if (e.cnt) begin
        n_fs  += int'(frame_start);
        n_ls  += int'(line_start);
        n_de  += int'(de);
        n_hs  += int'(!hsync);
        n_vs  += int'(!vsync);
        n_rgb += int'(rgb != 12'h000);
      end
    end
  end

  initial begin
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);                 // reset wins over en
    step(1'b1, 1'b0);
    cnt_on = 1'b1;
    repeat (HT * VT) step(1'b0, 1'b1); // one whole frame from (0,0) to (23,9)
    cnt_on = 1'b0;
    repeat (7) step(1'b0, 1'b0);       // stall at the last pixel of the frame
    repeat (80) step(1'b0, 1'b1);      // wraps to (0,0) then runs into line 3
    step(1'b1, 1'b1);                  // mid-frame reset
    step(1'b0, 1'b0);                  // reset values hold while disabled
    repeat (40) step(1'b0, 1'b1);
    repeat (150) step(1'b0, 1'($urandom_range(0, 1)));
    repeat (3) @(posedge clk);
    #2;
    chk("queue_drained", q.size(), 0);
    chk("frame_start_count", n_fs, 1);
    chk("line_start_count", n_ls, VT);
    chk("de_count", n_de, HA * VA);
    chk("hsync_low_count", n_hs, HS * VT);
    chk("vsync_low_count", n_vs, VS * HT);
`ifdef VGA_TEST_PATTERN_EN
    chk("rgb_lit_count", n_rgb, (HA - HA / 8) * VA);
`else
    chk("rgb_lit_count", n_rgb, 0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
